// File: rtl/scan_sequencer_4.sv
// scan_sequencer_4
//   Programmable 4-bit index sequencer feeding a 4-to-16 decoder stage.
//   The index steps once every (dvsr+1) clocks while running, in up, down,
//   ping-pong or hold pattern, and a one-cycle wrap pulse marks each sweep.
// Ports:
//   clk    - system clock, rising edge
//   reset  - synchronous, active-high reset
//   start  - 1 = begin or restart scanning (stop wins when both are high)
//   stop   - 1 = halt scanning, index frozen
//   mode   - 00 up, 01 down, 10 ping-pong, 11 hold
//   dvsr   - step period minus one, in clk cycles
//   en     - decoder enable (registered, 1 while running)
//   a      - decoder select index (registered)
//   wrap   - one-cycle pulse when a step wraps the sequence (registered)
module scan_sequencer_4 #(
  parameter int unsigned DVSR_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic [1:0]        mode,
  input  logic [DVSR_W-1:0] dvsr,
  output logic              en,
  output logic [3:0]        a,
  output logic              wrap
);

  typedef enum logic {IDLE, RUN} state_t;
  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;
  typedef enum logic [1:0] {M_UP = 2'b00, M_DOWN = 2'b01, M_PING = 2'b10, M_HOLD = 2'b11} mode_t;

  state_t            state_q, state_d;
  dir_t              dir_q, dir_d;
  logic [DVSR_W-1:0] presc_q, presc_d;
  logic [3:0]        a_q, a_d;
  logic              en_q, en_d;
  logic              wrap_q, wrap_d;
  logic [3:0]        load_a;
  mode_t             mode_m;

  assign mode_m = mode_t'(mode);

  always_comb begin
    unique case (mode_m)
      M_DOWN:  load_a = 4'hf;
      M_HOLD:  load_a = a_q;
      default: load_a = 4'h0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    presc_d = presc_q;
    a_d     = a_q;
    wrap_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        presc_d = '0;
        if (start && !stop) begin
          state_d = RUN;
          a_d     = load_a;
          dir_d   = DIR_UP;
        end
      end
      RUN: begin
        if (stop) begin
          state_d = IDLE;
          presc_d = '0;
        end else if (start) begin
          a_d     = load_a;
          presc_d = '0;
          dir_d   = DIR_UP;
        end else if (presc_q >= dvsr) begin
          // >= rather than == so a lowered dvsr steps immediately
          presc_d = '0;
          unique case (mode_m)
            M_UP: begin
              a_d    = a_q + 4'd1;
              wrap_d = (a_q == 4'hf);
            end
            M_DOWN: begin
              a_d    = a_q - 4'd1;
              wrap_d = (a_q == 4'h0);
            end
            M_PING: begin
              if (a_q == 4'hf) begin
                a_d   = 4'he;
                dir_d = DIR_DOWN;
              end else if (a_q == 4'h0) begin
                a_d   = 4'h1;
                dir_d = DIR_UP;
              end else if (dir_q == DIR_UP) begin
                a_d = a_q + 4'd1;
              end else begin
                a_d    = a_q - 4'd1;
                wrap_d = (a_q == 4'h1);
              end
            end
            default: ;
          endcase
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (mode_m != M_PING) dir_d = DIR_UP;
    en_d = (state_d == RUN);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      dir_q   <= DIR_UP;
      presc_q <= '0;
      a_q     <= '0;
      en_q    <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      presc_q <= presc_d;
      a_q     <= a_d;
      en_q    <= en_d;
      wrap_q  <= wrap_d;
    end
  end

  assign en   = en_q;
  assign a    = a_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_sequencer_4.sv
// Testbench for scan_sequencer_4: directed scenarios plus randomized run,
// checked against a behavioural model kept in the bench.
module tb_scan_sequencer_4;

  logic        clk = 1'b0;
  logic        reset, start, stop;
  logic [1:0]  mode;
  logic [15:0] dvsr;
  logic        en, wrap;
  logic [3:0]  a;

  int errors = 0;
  int checks = 0;

  // behavioural model state
  bit m_run;
  int m_a, m_cnt, m_wrap;
  bit m_down;

  scan_sequencer_4 #(.DVSR_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop),
    .mode(mode), .dvsr(dvsr), .en(en), .a(a), .wrap(wrap)
  );

  always #5 clk = ~clk;

  // Ping-pong treated as a 30-step cycle: phase 0..15 rising, 16..29 falling.
  task automatic model_step();
    int ph;
    if (reset) begin
      m_run = 0; m_a = 0; m_cnt = 0; m_wrap = 0; m_down = 0;
      return;
    end
    m_wrap = 0;
    if (stop) begin
      m_run = 0; m_cnt = 0;
    end else if (start) begin
      m_run = 1; m_cnt = 0; m_down = 0;
      if (mode == 2'd0 || mode == 2'd2) m_a = 0;
      else if (mode == 2'd1) m_a = 15;
    end else if (m_run) begin
      if (m_cnt >= int'(dvsr)) begin
        m_cnt = 0;
        case (mode)
          2'd0: begin m_a = (m_a + 1) % 16; m_wrap = (m_a == 0); end
          2'd1: begin m_a = (m_a + 15) % 16; m_wrap = (m_a == 15); end
          2'd2: begin
            if (!m_down || m_a == 0) ph = m_a; else ph = 30 - m_a;
            ph = (ph + 1) % 30;
            m_a = (ph <= 15) ? ph : 30 - ph;
            m_down = (ph > 15);
            m_wrap = (ph == 0);
          end
          default: ;
        endcase
      end else begin
        m_cnt++;
      end
    end
    if (mode != 2'd2) m_down = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1; start = 0; stop = 0;
    tick();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; start = 1; stop = 0; mode = 2'd0; dvsr = 16'd0;
    tick(); tick();
    checks++;
    if (en !== 1'b0 || a !== 4'd0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL reset: en=%b a=%0d wrap=%b, required en=0 a=0 wrap=0", en, a, wrap);
    end
    reset = 0; start = 0;
  endtask

  task automatic test_up();
    int exp_a;
    do_reset();
    mode = 2'd0; dvsr = 16'd0; start = 1;
    tick();
    start = 0;
    checks++;
    if (en !== 1'b1 || a !== 4'd0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL up_start: en=%b a=%0d wrap=%b, required en=1 a=0 wrap=0", en, a, wrap);
    end
    for (int k = 1; k <= 17; k++) begin
      tick();
      exp_a = k % 16;
      checks++;
      if (en !== 1'b1 || a !== exp_a[3:0] || wrap !== (k == 16)) begin
        errors++;
        $display("FAIL up_seq k=%0d: en=%b a=%0d wrap=%b, required en=1 a=%0d wrap=%0d",
                 k, en, a, wrap, exp_a, (k == 16));
      end
    end
  endtask

  task automatic test_dvsr();
    int exp_a;
    do_reset();
    mode = 2'd0; dvsr = 16'd3; start = 1;
    tick();
    start = 0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_a = k / 4;
      checks++;
      if (a !== exp_a[3:0] || wrap !== 1'b0) begin
        errors++;
        $display("FAIL dvsr3 k=%0d: a=%0d wrap=%b, required a=%0d wrap=0", k, a, wrap, exp_a);
      end
    end
  endtask

  task automatic test_down();
    int exp_a;
    do_reset();
    mode = 2'd1; dvsr = 16'd0; start = 1;
    tick();
    start = 0;
    for (int k = 0; k <= 17; k++) begin
      if (k > 0) tick();
      exp_a = ((15 - k) % 16 + 16) % 16;
      checks++;
      if (en !== 1'b1 || a !== exp_a[3:0] || wrap !== (k == 16)) begin
        errors++;
        $display("FAIL down_seq k=%0d: a=%0d wrap=%b, required a=%0d wrap=%0d",
                 k, a, wrap, exp_a, (k == 16));
      end
    end
  endtask

  task automatic test_pingpong();
    int exp_a, ph;
    do_reset();
    mode = 2'd2; dvsr = 16'd0; start = 1;
    tick();
    start = 0;
    for (int k = 0; k <= 32; k++) begin
      if (k > 0) tick();
      ph = k % 30;
      exp_a = (ph <= 15) ? ph : 30 - ph;
      checks++;
      if (a !== exp_a[3:0] || wrap !== (k == 30)) begin
        errors++;
        $display("FAIL ping_seq k=%0d: a=%0d wrap=%b, required a=%0d wrap=%0d",
                 k, a, wrap, exp_a, (k == 30));
      end
    end
  endtask

  task automatic test_stop_start();
    do_reset();
    mode = 2'd0; dvsr = 16'd0; start = 1;
    tick();
    start = 0;
    repeat (7) tick();
    stop = 1;
    tick();
    stop = 0;
    checks++;
    if (en !== 1'b0 || a !== 4'd7) begin
      errors++;
      $display("FAIL stop: en=%b a=%0d, required en=0 a=7", en, a);
    end
    for (int k = 0; k < 10; k++) begin
      tick();
      checks++;
      if (en !== 1'b0 || a !== 4'd7 || wrap !== 1'b0) begin
        errors++;
        $display("FAIL stop_hold k=%0d: en=%b a=%0d wrap=%b, required en=0 a=7 wrap=0", k, en, a, wrap);
      end
    end
    start = 1; stop = 1;
    tick();
    checks++;
    if (en !== 1'b0 || a !== 4'd7) begin
      errors++;
      $display("FAIL start_and_stop: en=%b a=%0d, required en=0 a=7", en, a);
    end
    stop = 0;
    tick();
    start = 0;
    checks++;
    if (en !== 1'b1 || a !== 4'd0) begin
      errors++;
      $display("FAIL restart: en=%b a=%0d, required en=1 a=0", en, a);
    end
  endtask

  task automatic test_dvsr_change_reset();
    int guard;
    do_reset();
    mode = 2'd0; dvsr = 16'd100; start = 1;
    tick();
    start = 0;
    guard = 0;
    while (m_cnt != 50 && guard < 200) begin
      tick();
      guard++;
    end
    checks++;
    if (guard >= 200 || a !== 4'd0) begin
      errors++;
      $display("FAIL dvsr_pre: a=%0d guard=%0d, required a=0 within budget", a, guard);
    end
    dvsr = 16'd10;
    tick();
    checks++;
    if (a !== 4'd1) begin
      errors++;
      $display("FAIL dvsr_lower: a=%0d, required 1", a);
    end
    for (int k = 1; k <= 22; k++) begin
      tick();
      checks++;
      if (a !== 4'(1 + k / 11)) begin
        errors++;
        $display("FAIL dvsr_period k=%0d: a=%0d, required %0d", k, a, 1 + k / 11);
      end
    end
    reset = 1;
    tick();
    reset = 0;
    checks++;
    if (en !== 1'b0 || a !== 4'd0 || wrap !== 1'b0) begin
      errors++;
      $display("FAIL midrun_reset: en=%b a=%0d wrap=%b, required 0 0 0", en, a, wrap);
    end
    tick();
    checks++;
    if (en !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_idle: en=%b, required 0", en);
    end
  endtask

  task automatic test_random();
    do_reset();
    mode = 2'd0; dvsr = 16'd0;
    for (int k = 0; k < 3000; k++) begin
      reset = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 29) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 24) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) dvsr = 16'($urandom_range(0, 4));
      tick();
      checks++;
      if (en !== m_run || a !== m_a[3:0] || wrap !== m_wrap[0]) begin
        errors++;
        $display("FAIL random k=%0d: en=%b a=%0d wrap=%b, required en=%0d a=%0d wrap=%0d",
                 k, en, a, wrap, m_run, m_a, m_wrap);
      end
    end
    reset = 0; start = 0; stop = 0;
  endtask

  initial begin
    reset = 1; start = 0; stop = 0; mode = 2'd0; dvsr = 16'd0;
    m_run = 0; m_a = 0; m_cnt = 0; m_wrap = 0; m_down = 0;
    test_reset();
    test_up();
    test_dvsr();
    test_down();
    test_pingpong();
    test_stop_start();
    test_dvsr_change_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
